// File: rtl/ws_retire_buf_if.sv
// Bundle of the MEM->WB handshake, register-file write port, exception report
// and debug trace signals of the writeback retire buffer.
interface ws_retire_buf_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
);
  localparam int BE_W = DATA_W / 8;

  // MEM->WB: an instruction transfers on a cycle where ms_to_ws_valid && ws_allowin;
  // MEM holds its fields stable while valid is high and not yet accepted.
  logic                   ms_to_ws_valid;
  logic                   ws_allowin;
  logic [PC_W-1:0]        ms_pc;
  logic                   ms_gr_we;
  logic [BE_W-1:0]        ms_rf_be;
  logic [REG_AW-1:0]      ms_dest;
  logic [DATA_W-1:0]      ms_result;
  logic                   ms_ex;

  logic                   rf_ready;
  logic [BE_W-1:0]        rf_we;
  logic [REG_AW-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;

  logic                   ws_ex;
  logic [PC_W-1:0]        ws_ex_pc;
  logic [2**REG_AW-1:0]   pend_mask;

  logic [PC_W-1:0]        debug_wb_pc;
  logic [BE_W-1:0]        debug_wb_rf_wen;
  logic [REG_AW-1:0]      debug_wb_rf_wnum;
  logic [DATA_W-1:0]      debug_wb_rf_wdata;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_rf_be, ms_dest, ms_result, ms_ex, rf_ready,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ws_ex, ws_ex_pc, pend_mask,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_rf_be, ms_dest, ms_result, ms_ex, rf_ready,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ws_ex, ws_ex_pc, pend_mask,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/ws_retire_buf.sv
// Writeback stage with an in-order retire buffer in front of a stallable
// register-file write port; an excepting head retires at once and flushes.
module ws_retire_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  ws_retire_buf_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]   r_pc     [DEPTH];
  logic              r_gr_we  [DEPTH];
  logic [BE_W-1:0]   r_be     [DEPTH];
  logic [REG_AW-1:0] r_dest   [DEPTH];
  logic [DATA_W-1:0] r_result [DEPTH];
  logic              r_ex     [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic                 w_head_valid;
  logic                 w_head_ex;
  logic                 w_flush;
  logic                 w_retire;
  logic                 w_push;
  logic                 w_allowin;
  logic [BE_W-1:0]      w_rf_we;
  logic [2**REG_AW-1:0] w_pend_mask;

  assign w_head_valid = (r_count != '0);
  assign w_head_ex    = w_head_valid && r_ex[r_head];
  // An excepting head does not wait for the port, so it always flushes this cycle.
  assign w_flush      = w_head_ex;
  assign w_retire     = w_head_valid && (bus.rf_ready || r_ex[r_head]);
  assign w_allowin    = (r_count < CNT_FULL) && !w_flush;
  assign w_push       = bus.ms_to_ws_valid && w_allowin;

  assign w_rf_we = (w_retire && !r_ex[r_head] && r_gr_we[r_head] && (r_dest[r_head] != '0))
                   ? r_be[r_head] : '0;

  always_comb begin
    w_pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && r_gr_we[PTR_W'(r_head + PTR_W'(i))]
          && (r_dest[PTR_W'(r_head + PTR_W'(i))] != '0))
        w_pend_mask[r_dest[PTR_W'(r_head + PTR_W'(i))]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)   r_tail <= r_tail + 1'b1;
      if (w_retire) r_head <= r_head + 1'b1;
      if (w_push && !w_retire)      r_count <= r_count + 1'b1;
      else if (!w_push && w_retire) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage carries no reset; validity comes only from the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]     <= bus.ms_pc;
      r_gr_we[r_tail]  <= bus.ms_gr_we;
      r_be[r_tail]     <= bus.ms_rf_be;
      r_dest[r_tail]   <= bus.ms_dest;
      r_result[r_tail] <= bus.ms_result;
      r_ex[r_tail]     <= bus.ms_ex;
    end
  end

  assign bus.ws_allowin        = w_allowin;
  assign bus.rf_we             = w_rf_we;
  assign bus.rf_waddr          = w_head_valid ? r_dest[r_head]   : '0;
  assign bus.rf_wdata          = w_head_valid ? r_result[r_head] : '0;
  assign bus.ws_ex             = w_flush;
  assign bus.ws_ex_pc          = w_head_valid ? r_pc[r_head]     : '0;
  assign bus.pend_mask         = w_pend_mask;
  assign bus.debug_wb_pc       = w_head_valid ? r_pc[r_head]     : '0;
  assign bus.debug_wb_rf_wen   = w_rf_we;
  assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
  assign bus.debug_wb_rf_wdata = bus.rf_wdata;
endmodule

// File: tb/tb_ws_retire_buf.sv
// Directed self-checking bench for ws_retire_buf (DEPTH=4, 32-bit data).
module tb_ws_retire_buf;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  ws_retire_buf_if #(.DATA_W(32), .REG_AW(5), .PC_W(32)) bus ();

  ws_retire_buf #(.DATA_W(32), .REG_AW(5), .PC_W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                       input logic [3:0] be, input logic [4:0] dest,
                       input logic [31:0] data, input logic ex);
    bus.ms_to_ws_valid = v;
    bus.ms_pc          = pc;
    bus.ms_gr_we       = we;
    bus.ms_rf_be       = be;
    bus.ms_dest        = dest;
    bus.ms_result      = data;
    bus.ms_ex          = ex;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] we, input logic [4:0] wa,
                        input logic [31:0] wd);
    chk({tag, ".rf_we"},    64'(bus.rf_we), 64'(we));
    chk({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(wa));
    chk({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(wd));
    chk({tag, ".dbg_wen"},  64'(bus.debug_wb_rf_wen), 64'(we));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.rf_ready = 1'b0;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // reset state
    chk("rst.rf_we",     64'(bus.rf_we), 64'h0);
    chk("rst.ws_ex",     64'(bus.ws_ex), 64'h0);
    chk("rst.pend",      64'(bus.pend_mask), 64'h0);
    chk("rst.dbg_pc",    64'(bus.debug_wb_pc), 64'h0);
    chk("rst.waddr",     64'(bus.rf_waddr), 64'h0);
    chk("rst.wdata",     64'(bus.rf_wdata), 64'h0);
    chk("rst.ex_pc",     64'(bus.ws_ex_pc), 64'h0);
    chk("rst.allowin",   64'(bus.ws_allowin), 64'h1);

    // 1: six back-to-back pushes, port always ready
    bus.rf_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h1000 + 32'(4 * k), 1'b1, 4'hF, 5'(k + 1), 32'(17 * (k + 1)), 1'b0);
      chk("b2b.allowin", 64'(bus.ws_allowin), 64'h1);
      if (k == 0) begin
        chk_wr("b2b.first", 4'h0, 5'd0, 32'h0);
        chk("b2b.pend0", 64'(bus.pend_mask), 64'h0);
      end else begin
        chk_wr("b2b", 4'hF, 5'(k), 32'(17 * k));
        chk("b2b.dbg_pc", 64'(bus.debug_wb_pc), 64'(32'h1000 + 32'(4 * (k - 1))));
        chk("b2b.pend", 64'(bus.pend_mask), 64'(32'h1 << k));
      end
      tick();
    end
    idle();
    chk_wr("b2b.last", 4'hF, 5'd6, 32'h66);
    tick();
    chk_wr("b2b.empty", 4'h0, 5'd0, 32'h0);
    chk("b2b.empty_pend", 64'(bus.pend_mask), 64'h0);

    // 2: port stalled while four pushes fill the buffer
    bus.rf_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1100 + 32'(4 * k), 1'b1, 4'hF, 5'(k + 1), 32'hA0 + 32'(k), 1'b0);
      chk("full.allowin_before", 64'(bus.ws_allowin), 64'h1);
      chk("full.no_write", 64'(bus.rf_we), 64'h0);
      tick();
    end
    drive(1'b1, 32'h1110, 1'b1, 4'hF, 5'd5, 32'hA4, 1'b0);
    chk("full.allowin_low", 64'(bus.ws_allowin), 64'h0);
    chk("full.pend", 64'(bus.pend_mask), 64'h1E);
    chk_wr("full.stalled", 4'h0, 5'd1, 32'hA0);
    tick();
    chk("full.still_low", 64'(bus.ws_allowin), 64'h0);
    chk("full.pend_hold", 64'(bus.pend_mask), 64'h1E);
    idle();
    bus.rf_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_wr("drain", 4'hF, 5'(k + 1), 32'hA0 + 32'(k));
      chk("drain.allowin", 64'(bus.ws_allowin), (k == 0) ? 64'h0 : 64'h1);
      tick();
    end
    chk("drain.empty_pend", 64'(bus.pend_mask), 64'h0);

    // 3: write to r0 is suppressed but still retires
    drive(1'b1, 32'h2000, 1'b1, 4'hF, 5'd0, 32'hDEADBEEF, 1'b0);
    chk("r0.pend_push", 64'(bus.pend_mask), 64'h0);
    tick();
    idle();
    chk("r0.rf_we", 64'(bus.rf_we), 64'h0);
    chk("r0.dbg_pc", 64'(bus.debug_wb_pc), 64'h2000);
    chk("r0.pend", 64'(bus.pend_mask), 64'h0);
    tick();
    chk("r0.dbg_pc_after", 64'(bus.debug_wb_pc), 64'h0);

    // 4: exception in second slot flushes the younger entries
    bus.rf_ready = 1'b0;
    drive(1'b1, 32'h3000, 1'b1, 4'hF, 5'd8,  32'h80808080, 1'b0); tick();
    drive(1'b1, 32'hBFC00380, 1'b1, 4'hF, 5'd9, 32'h90909090, 1'b1); tick();
    drive(1'b1, 32'h3008, 1'b1, 4'hF, 5'd10, 32'hA0A0A0A0, 1'b0); tick();
    drive(1'b1, 32'h300C, 1'b1, 4'hF, 5'd11, 32'hB0B0B0B0, 1'b0); tick();
    bus.rf_ready = 1'b1;
    drive(1'b1, 32'h3010, 1'b1, 4'hF, 5'd12, 32'hC0C0C0C0, 1'b0);
    chk_wr("ex.A", 4'hF, 5'd8, 32'h80808080);
    chk("ex.A_no_ex", 64'(bus.ws_ex), 64'h0);
    chk("ex.A_pend", 64'(bus.pend_mask), 64'hF00);
    tick();
    chk("ex.pulse", 64'(bus.ws_ex), 64'h1);
    chk("ex.pc", 64'(bus.ws_ex_pc), 64'hBFC00380);
    chk("ex.no_write", 64'(bus.rf_we), 64'h0);
    chk("ex.refuse", 64'(bus.ws_allowin), 64'h0);
    chk("ex.pend", 64'(bus.pend_mask), 64'hE00);
    tick();
    idle();
    chk("ex.after_pulse", 64'(bus.ws_ex), 64'h0);
    chk("ex.after_pend", 64'(bus.pend_mask), 64'h0);
    chk("ex.after_dbg_pc", 64'(bus.debug_wb_pc), 64'h0);
    chk("ex.after_allowin", 64'(bus.ws_allowin), 64'h1);
    chk("ex.after_we", 64'(bus.rf_we), 64'h0);

    // 5: partial byte-enable write
    drive(1'b1, 32'h4000, 1'b1, 4'h3, 5'd7, 32'hAABBCCDD, 1'b0);
    tick();
    idle();
    chk_wr("part", 4'h3, 5'd7, 32'hAABBCCDD);
    chk("part.dbg_wnum", 64'(bus.debug_wb_rf_wnum), 64'h7);
    chk("part.dbg_wdata", 64'(bus.debug_wb_rf_wdata), 64'hAABBCCDD);
    tick();

    // 6: reset with three entries buffered, then ten pushes across the wrap
    bus.rf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h5000 + 32'(4 * k), 1'b1, 4'hF, 5'(12 + k), 32'h5 + 32'(k), 1'b0);
      tick();
    end
    idle();
    chk("mid.pend", 64'(bus.pend_mask), 64'h7000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid.rst_pend", 64'(bus.pend_mask), 64'h0);
    chk("mid.rst_we", 64'(bus.rf_we), 64'h0);
    chk("mid.rst_dbg_pc", 64'(bus.debug_wb_pc), 64'h0);
    chk("mid.rst_allowin", 64'(bus.ws_allowin), 64'h1);
    bus.rf_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h6000 + 32'(4 * k), 1'b1, 4'hF, 5'(k + 1), 32'h100 + 32'(k), 1'b0);
      if (k > 0) chk_wr("wrap", 4'hF, 5'(k), 32'h100 + 32'(k - 1));
      tick();
    end
    idle();
    chk_wr("wrap.last", 4'hF, 5'd10, 32'h109);
    chk("wrap.last_pc", 64'(bus.debug_wb_pc), 64'h6024);
    tick();
    chk("wrap.empty_pend", 64'(bus.pend_mask), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
